// File: rtl/cpu_mult_pkg.sv
// Shared definitions for the CPU multiplier arbiter.
// The optional round-robin arbitration is selected with CPU_MULT_ARB_RR_EN
// (tested only inside cpu_mult_arb_rr).
package cpu_mult_pkg;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 2;
    localparam int LATENCY = 2;

    // One multiply request as presented by a requester.
    typedef struct packed {
        logic [WIDTH-1:0] src1;
        logic [WIDTH-1:0] src2;
        logic             src1_signed;
        logic             src2_signed;
    } mult_req_t;

    // Ownership tag travelling alongside a product in the cell pipeline.
    typedef struct packed {
        logic valid;
        logic id;
    } mult_tag_t;

    // One-hot ready vector for a granted port.
    function automatic logic [NUM_REQ-1:0] port_onehot(input logic id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/cpu_mult_arb_rr.sv
// Two-way grant logic for the shared multiplier.
// CPU_MULT_ARB_RR_EN defined: round-robin using a `last` pointer (reset 1,
// so port 0 wins first). Undefined: fixed priority, port 0 always wins.
module cpu_mult_arb_rr
    import cpu_mult_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               grant_valid,
    output logic               grant_id
);

`ifdef CPU_MULT_ARB_RR_EN
    logic last_q;
    logic last_d;

    // Grant selection: on contention the port not granted last time wins.
    always_comb begin
        grant_valid = |req_valid;
        grant_id    = 1'b0;
        last_d      = last_q;
        if (&req_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = req_valid[1];
        end
        if (grant_valid) begin
            last_d = grant_id;
        end
        req_ready = grant_valid ? port_onehot(grant_id) : '0;
    end

    // Priority pointer; moves only when a grant is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Clock and reset have no load in the fixed-priority build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;

    // Grant selection: port 0 always wins; port 1 only when port 0 is idle.
    always_comb begin
        grant_valid = |req_valid;
        grant_id    = ~req_valid[0] & req_valid[1];
        req_ready   = grant_valid ? port_onehot(grant_id) : '0;
    end
`endif

endmodule

// File: rtl/cpu_mult_arbiter.sv
// Shares one pipelined multiplier cell (registered inputs, registered low-word
// result) between the execute stage (port 0) and a custom-instruction slave
// (port 1). Results return to their owner exactly LATENCY cycles after grant.
// Arbitration policy is chosen by CPU_MULT_ARB_RR_EN (see cpu_mult_arb_rr).
module cpu_mult_arbiter
    import cpu_mult_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_src1,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_src2,
    input  logic [NUM_REQ-1:0]            req_src1_signed,
    input  logic [NUM_REQ-1:0]            req_src2_signed,
    input  logic                          flush,
    output logic                          rsp_valid,
    output logic                          rsp_id,
    output logic [WIDTH-1:0]              rsp_result,
    output logic [WIDTH-1:0]              cell_dataa,
    output logic [WIDTH-1:0]              cell_datab,
    output logic                          cell_signa,
    output logic                          cell_signb,
    output logic                          cell_en0,
    output logic                          cell_en1,
    output logic                          cell_rotate,
    output logic                          cell_shift_right,
    input  logic [WIDTH-1:0]              cell_result
);

    // Handshake: a request transfers in the cycle req_valid[p] && req_ready[p];
    // at most one ready is high. Responses are a one-cycle rsp_valid pulse
    // with no back-pressure, so the owner must take it.

    logic      grant_valid;
    logic      grant_id;
    mult_req_t grant_req;
    mult_tag_t s1_q, s1_d;
    mult_tag_t s2_q, s2_d;

    cpu_mult_arb_rr u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Operand mux: the granted port drives the cell, otherwise zeros.
    always_comb begin
        grant_req = '0;
        if (grant_valid) begin
            grant_req.src1        = req_src1[grant_id];
            grant_req.src2        = req_src2[grant_id];
            grant_req.src1_signed = req_src1_signed[grant_id];
            grant_req.src2_signed = req_src2_signed[grant_id];
        end
    end

    assign cell_dataa       = grant_req.src1;
    assign cell_datab       = grant_req.src2;
    assign cell_signa       = grant_req.src1_signed;
    assign cell_signb       = grant_req.src2_signed;
    // The pipeline never stalls, so both cell stages are always enabled.
    assign cell_en0         = 1'b1;
    assign cell_en1         = 1'b1;
    assign cell_rotate      = 1'b0;
    assign cell_shift_right = 1'b0;

    // Tag pipeline next state: mirrors the cell's two register stages;
    // flush kills everything in flight including this cycle's grant.
    always_comb begin
        s1_d       = '0;
        s2_d       = '0;
        if (!flush) begin
            s1_d.valid = grant_valid;
            s1_d.id    = grant_id;
            s2_d       = s1_q;
        end
    end

    // Tag pipeline registers; async reset guarantees no response escapes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign rsp_valid  = s2_q.valid;
    assign rsp_id     = s2_q.id;
    assign rsp_result = cell_result;

endmodule
